control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit sitting directly upstream of the datapath; replaces bench-driven control strobes with an FSM.
- Each clock it produces one control step (T0..T7) for the instruction held in IR.
- Drives register-file select (Gra/Grb/Grc with Rin/Rout), bus-source strobes, register-enable strobes, memory Read/Write and the 5-bit ALU opcode.
- Instruction format: IR[31:27] = opcode. Register fields are decoded inside the datapath.

Parameters:
STEP_W, 4, width of internal step encoding (states RST, T0..T7, HALT)

Ports:
Clock  in  1  system clock, all state changes on rising edge
Reset  in  1  asynchronous, active-low reset
IR  in  32  current instruction from datapath IR register
Stop  in  1  request halt after current instruction completes
Step  in  1  single-step advance pulse (used only when CU_SINGLE_STEP_EN defined)
PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout  out  1 each  bus-source strobes
PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register-enable strobes
Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select and direction
IncPC, Read, Write  out  1 each  PC increment, memory read/write
opcode  out  5  ALU operation code to datapath
Run  out  1  high while executing; low in RST and HALT

Behaviour:
- Reset low (async): state=RST, every output 0, opcode=5'b00000.
- First rising edge with Reset high: RST->T0, Run=1.
- Outputs are Moore-decoded from the state register plus IR[31:27]; each step lasts exactly one clock.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- R-type (add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, neg 10001, not 10010):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, opcode=IR[31:27].
  - T5: Zlowout, Gra, Rin. Then ->T0.
- Immediate (addi 01100, andi 01101, ori 01110):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, opcode=add/and/or code respectively.
  - T5: Zlowout, Gra, Rin. Then ->T0.
- ld 00000:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, opcode=00011.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin. Then ->T0.
- ldi 00001: T3-T4 as ld; T5: Zlowout, Gra, Rin. Then ->T0.
- st 00010: T3-T5 as ld; T6: Gra, Rout, MDRin; T7: Write. Then ->T0.
- mul 01111 / div 10000:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, opcode=IR[31:27].
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Then ->T0.
- mfhi 11000: T3: HIout, Gra, Rin. mflo 11001: T3: LOout, Gra, Rin. Then ->T0.
- nop 11010 and any unlisted opcode: T3 with all strobes 0, then ->T0.
- halt 11011: T3->HALT. HALT holds all outputs 0, Run=0; only Reset exits.
- opcode output = 0 in every step not listed above.
- Stop: sampled at the final step of each instruction. If high, next state is HALT instead of T0. Stop arriving mid-instruction never truncates it.
- Reset asserted mid-instruction: immediate return to RST, all strobes drop the same instant. No partial write is completed.
- At most one bus-source strobe is asserted in any step.

Optional Feature:
CU_SINGLE_STEP_EN.
- Defined: after each instruction's final step the FSM goes to WAIT (Run=1, all strobes 0). It advances to T0 on the first clock where Step=1. A Step held high advances only one instruction (rising-edge detect on a registered copy of Step). Stop in WAIT goes to HALT.
- Undefined: Step is ignored and WAIT is never entered.

Decomposition:
- Package cpu_pkg: 5-bit opcode localparams (OP_LD..OP_HALT), state encodings (ST_RST, ST_T0..ST_T7, ST_HALT, ST_WAIT).
- One sub-module, step_decoder: combinational state+opcode -> strobe vector. The top holds the state register and next-state logic.

Test Plan:
- Reset low 3 cycles then high, IR=0 -> all strobes 0 during reset; first cycle after release asserts PCout, MARin, IncPC, Zin; Run=1.
- IR=0x18918000 (add R1,R2,R3) -> T3 Grb/Rout/Yin; T4 opcode=00011 with Zin; T5 Zlowout/Gra/Rin; T0 on the 7th cycle.
- IR=0x00800055 (ld) -> T6 Read+MDRin, T7 MDRout+Gra+Rin; exactly 8 cycles per instruction.
- IR=0x78900000 (mul) -> T5 Zlowout+LOin, T6 Zhighout+HIin; opcode=01111 only in T4.
- Stop pulsed during T4 of add -> T5 completes, then HALT, Run=0; further IR changes ignored until Reset.
- Reset pulled low during T6 of st -> Write never asserts; restart begins at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the hardwired control sequencer:
//   - 5-bit instruction opcodes (IR[31:27])
//   - control-step state encoding (RST, T0..T7, HALT, WAIT)
//   - the packed control-strobe bundle produced by the step decoder
//   - small opcode-classification helpers
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int STEP_W = 4;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [STEP_W-1:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9,
        ST_WAIT = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_out;
        logic       zhigh_out;
        logic       zlow_out;
        logic       mdr_out;
        logic       hi_out;
        logic       lo_out;
        logic       ba_out;
        logic       c_out;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic [4:0] alu_op;
        logic       run;
    } ctrl_t;

    // Register-register ALU operations: Y <- Rb, Z <- Y op Rc, Ra <- Zlow
    function automatic logic is_rtype(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
                          OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT};
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI};
    endfunction

    // Last control step of each instruction; everything unlisted ends at T3
    function automatic state_t last_step(input logic [4:0] op);
        if (op == OP_LD || op == OP_ST)
            return ST_T7;
        else if (op == OP_MUL || op == OP_DIV)
            return ST_T6;
        else if (op == OP_LDI || is_rtype(op) || is_imm(op))
            return ST_T5;
        else
            return ST_T3;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
// Bundle between the control sequencer and the datapath.
//   IR, Stop, Step        : datapath/operator -> sequencer
//   bus-source strobes    : PCout Zhighout Zlowout MDRout HIout LOout BAout Cout
//   register enables      : PCin MARin MDRin IRin Yin Zin HIin LOin
//   register-file control : Gra Grb Grc Rin Rout
//   misc                  : IncPC Read Write, opcode[4:0], Run
// Modports: master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface control_sequencer_if;

    logic [31:0] IR;
    logic        Stop;
    logic        Step;

    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic IncPC, Read, Write;
    logic [4:0] opcode;
    logic Run;

    modport master (
        input  IR, Stop, Step,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output Gra, Grb, Grc, Rin, Rout,
        output IncPC, Read, Write, opcode, Run
    );

    modport slave (
        output IR, Stop, Step,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  Gra, Grb, Grc, Rin, Rout,
        input  IncPC, Read, Write, opcode, Run
    );

endinterface

// File: rtl/step_decoder.sv
// ---------------------------------------------------------------------------
// step_decoder
// Purely combinational: current control step + instruction opcode -> full
// control-strobe bundle. Steps an instruction never reaches decode to zero.
//   state : current control step
//   op    : IR[31:27]
//   ctrl  : strobes, ALU opcode and Run
// ---------------------------------------------------------------------------
module step_decoder
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    output ctrl_t      ctrl
);

    logic mem_class;
    logic muldiv;

    assign mem_class = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign muldiv    = (op == OP_MUL) || (op == OP_DIV);

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1; ctrl.z_in   = 1'b1;
            end
            ST_T1: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_in  = 1'b1;
                ctrl.read     = 1'b1; ctrl.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            ST_T3: begin
                if (is_rtype(op) || is_imm(op)) begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                end else if (mem_class) begin
                    // base register passes through BAout so R0 reads as zero
                    ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                end else if (muldiv) begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                end else if (op == OP_MFHI) begin
                    ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (op == OP_MFLO) begin
                    ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end
            end
            ST_T4: begin
                if (is_rtype(op)) begin
                    ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                    ctrl.alu_op = op;
                end else if (is_imm(op)) begin
                    ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
                    case (op)
                        OP_ADDI: ctrl.alu_op = OP_ADD;
                        OP_ANDI: ctrl.alu_op = OP_AND;
                        default: ctrl.alu_op = OP_OR;
                    endcase
                end else if (mem_class) begin
                    // effective address = base + sign-extended constant
                    ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = OP_ADD;
                end else if (muldiv) begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                    ctrl.alu_op = op;
                end
            end
            ST_T5: begin
                if (is_rtype(op) || is_imm(op) || op == OP_LDI) begin
                    ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (op == OP_LD || op == OP_ST) begin
                    ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                end else if (muldiv) begin
                    ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
                end
            end
            ST_T6: begin
                if (op == OP_LD) begin
                    ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                end else if (op == OP_ST) begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                end else if (muldiv) begin
                    ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
                end
            end
            ST_T7: begin
                if (op == OP_LD) begin
                    ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (op == OP_ST) begin
                    ctrl.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit: one control step (T0..T7) per clock for the
// instruction in IR, Moore outputs decoded from the step register and
// IR[31:27].
//   Clock : system clock (rising edge)
//   Reset : asynchronous, active-low; forces RST and zero outputs at once
//   bus   : control_sequencer_if.master (IR/Stop/Step in, strobes out)
// Optional build macro CU_SINGLE_STEP_EN: park in WAIT after every
// instruction and advance only on a rising edge of Step.
// ---------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    control_sequencer_if.master  bus
);

    state_t     state_reg, state_next;
    logic       stop_pending_reg;
    logic       stop_req;
    logic [4:0] op;
    state_t     final_step;
    ctrl_t      ctrl;

    assign op         = bus.IR[31:27];
    assign final_step = last_step(op);
    // Stop is a request: remember it so a short pulse still halts at the
    // end of the instruction without ever truncating it.
    assign stop_req   = bus.Stop | stop_pending_reg;

`ifdef CU_SINGLE_STEP_EN
    logic step_reg;
    logic step_rise;

    assign step_rise = bus.Step & ~step_reg;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) step_reg <= 1'b0;
        else        step_reg <= bus.Step;
    end
`else
    logic unused_step;
    assign unused_step = bus.Step;
`endif

    logic unused_ir_fields;
    assign unused_ir_fields = ^bus.IR[26:0];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg        <= ST_RST;
            stop_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            stop_pending_reg <= stop_pending_reg | bus.Stop;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST:  state_next = ST_T0;
            ST_HALT: state_next = ST_HALT;
            ST_WAIT: begin
`ifdef CU_SINGLE_STEP_EN
                if (stop_req)       state_next = ST_HALT;
                else if (step_rise) state_next = ST_T0;
`else
                state_next = ST_T0;
`endif
            end
            ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (state_reg == final_step) begin
                    if (op == OP_HALT || stop_req)
                        state_next = ST_HALT;
                    else
`ifdef CU_SINGLE_STEP_EN
                        state_next = ST_WAIT;
`else
                        state_next = ST_T0;
`endif
                end else begin
                    state_next = state_t'(state_reg + 1'b1);
                end
            end
            default: state_next = ST_RST;
        endcase
    end

    step_decoder u_step_decoder (
        .state (state_reg),
        .op    (op),
        .ctrl  (ctrl)
    );

    assign bus.PCout    = ctrl.pc_out;
    assign bus.Zhighout = ctrl.zhigh_out;
    assign bus.Zlowout  = ctrl.zlow_out;
    assign bus.MDRout   = ctrl.mdr_out;
    assign bus.HIout    = ctrl.hi_out;
    assign bus.LOout    = ctrl.lo_out;
    assign bus.BAout    = ctrl.ba_out;
    assign bus.Cout     = ctrl.c_out;
    assign bus.PCin     = ctrl.pc_in;
    assign bus.MARin    = ctrl.mar_in;
    assign bus.MDRin    = ctrl.mdr_in;
    assign bus.IRin     = ctrl.ir_in;
    assign bus.Yin      = ctrl.y_in;
    assign bus.Zin      = ctrl.z_in;
    assign bus.HIin     = ctrl.hi_in;
    assign bus.LOin     = ctrl.lo_in;
    assign bus.Gra      = ctrl.gra;
    assign bus.Grb      = ctrl.grb;
    assign bus.Grc      = ctrl.grc;
    assign bus.Rin      = ctrl.r_in;
    assign bus.Rout     = ctrl.r_out;
    assign bus.IncPC    = ctrl.inc_pc;
    assign bus.Read     = ctrl.read;
    assign bus.Write    = ctrl.write;
    assign bus.opcode   = ctrl.alu_op;
    assign bus.Run      = ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Scoreboard bench: the stimulus process expands each instruction into its
// micro-program (one expected output word per clock) and queues it; the
// monitor pops one word per clock on the falling edge and compares.
// Expected word: {Run, opcode[4:0], 24 strobes}.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Strobe bit positions in the expected word
    localparam logic [23:0] M_PCOUT  = 24'h000001, M_ZHIGH  = 24'h000002;
    localparam logic [23:0] M_ZLOW   = 24'h000004, M_MDROUT = 24'h000008;
    localparam logic [23:0] M_HIOUT  = 24'h000010, M_LOOUT  = 24'h000020;
    localparam logic [23:0] M_BAOUT  = 24'h000040, M_COUT   = 24'h000080;
    localparam logic [23:0] M_PCIN   = 24'h000100, M_MARIN  = 24'h000200;
    localparam logic [23:0] M_MDRIN  = 24'h000400, M_IRIN   = 24'h000800;
    localparam logic [23:0] M_YIN    = 24'h001000, M_ZIN    = 24'h002000;
    localparam logic [23:0] M_HIIN   = 24'h004000, M_LOIN   = 24'h008000;
    localparam logic [23:0] M_GRA    = 24'h010000, M_GRB    = 24'h020000;
    localparam logic [23:0] M_GRC    = 24'h040000, M_RIN    = 24'h080000;
    localparam logic [23:0] M_ROUT   = 24'h100000, M_INCPC  = 24'h200000;
    localparam logic [23:0] M_READ   = 24'h400000, M_WRITE  = 24'h800000;
    localparam logic [29:0] IDLE     = 30'h0;

    logic [29:0] exp_q[$];
    logic [29:0] seq_q[$];
    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    // One active step: Run=1, given strobes and ALU code
    function automatic logic [29:0] act(input logic [23:0] m, input logic [4:0] alu);
        return {1'b1, alu, m};
    endfunction

    // Reference micro-program for one instruction, straight from the ISA table
    function automatic void build_seq(input logic [4:0] op);
        logic [4:0] imm_alu;
        seq_q.delete();
        seq_q.push_back(act(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));
        seq_q.push_back(act(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 5'd0));
        seq_q.push_back(act(M_MDROUT | M_IRIN, 5'd0));
        if (op inside {[5'd3:5'd11], 5'd17, 5'd18}) begin
            seq_q.push_back(act(M_GRB | M_ROUT | M_YIN, 5'd0));
            seq_q.push_back(act(M_GRC | M_ROUT | M_ZIN, op));
            seq_q.push_back(act(M_ZLOW | M_GRA | M_RIN, 5'd0));
        end else if (op inside {[5'd12:5'd14]}) begin
            imm_alu = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
            seq_q.push_back(act(M_GRB | M_ROUT | M_YIN, 5'd0));
            seq_q.push_back(act(M_COUT | M_ZIN, imm_alu));
            seq_q.push_back(act(M_ZLOW | M_GRA | M_RIN, 5'd0));
        end else if (op inside {[5'd0:5'd2]}) begin
            seq_q.push_back(act(M_GRB | M_BAOUT | M_YIN, 5'd0));
            seq_q.push_back(act(M_COUT | M_ZIN, 5'd3));
            if (op == 5'd1) begin
                seq_q.push_back(act(M_ZLOW | M_GRA | M_RIN, 5'd0));
            end else begin
                seq_q.push_back(act(M_ZLOW | M_MARIN, 5'd0));
                if (op == 5'd0) begin
                    seq_q.push_back(act(M_READ | M_MDRIN, 5'd0));
                    seq_q.push_back(act(M_MDROUT | M_GRA | M_RIN, 5'd0));
                end else begin
                    seq_q.push_back(act(M_GRA | M_ROUT | M_MDRIN, 5'd0));
                    seq_q.push_back(act(M_WRITE, 5'd0));
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            seq_q.push_back(act(M_GRA | M_ROUT | M_YIN, 5'd0));
            seq_q.push_back(act(M_GRB | M_ROUT | M_ZIN, op));
            seq_q.push_back(act(M_ZLOW | M_LOIN, 5'd0));
            seq_q.push_back(act(M_ZHIGH | M_HIIN, 5'd0));
        end else if (op == 5'd24) begin
            seq_q.push_back(act(M_HIOUT | M_GRA | M_RIN, 5'd0));
        end else if (op == 5'd25) begin
            seq_q.push_back(act(M_LOOUT | M_GRA | M_RIN, 5'd0));
        end else begin
            seq_q.push_back(act(24'h0, 5'd0));
        end
    endfunction

    // Called just after a rising edge: queue the expectation for this clock
    // and move on to just after the next rising edge.
    task automatic cyc(input logic [29:0] e);
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b0;
        bus.Stop = 1'b0;
        repeat (n) cyc(IDLE);
        Reset = 1'b1;
        cyc(IDLE);
    endtask

    // stop_at: -1 never, -2 random step, else the step index to pulse Stop
    task automatic run_instr(input logic [31:0] ir, input int stop_at, output bit halted);
        int s;
        bus.IR = ir;
        build_seq(ir[31:27]);
        s = (stop_at == -2) ? int'($urandom_range(0, seq_q.size() - 1)) : stop_at;
        for (int k = 0; k < seq_q.size(); k++) begin
            bus.Stop = (k == s);
            cyc(seq_q[k]);
        end
        bus.Stop = 1'b0;
        halted = (s >= 0) || (ir[31:27] == 5'd27);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.IR = $urandom;
            cyc(IDLE);
        end
    endtask

    // Monitor: one comparison per clock against the scoreboard head
    logic [29:0] got, want;
    always @(negedge Clock) begin
        cycle_no++;
        got = {bus.Run, bus.opcode, bus.Write, bus.Read, bus.IncPC, bus.Rout, bus.Rin,
               bus.Grc, bus.Grb, bus.Gra, bus.LOin, bus.HIin, bus.Zin, bus.Yin, bus.IRin,
               bus.MDRin, bus.MARin, bus.PCin, bus.Cout, bus.BAout, bus.LOout, bus.HIout,
               bus.MDRout, bus.Zlowout, bus.Zhighout, bus.PCout};
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL step cycle %0d: got run=%b op=%b strobes=%h, want run=%b op=%b strobes=%h",
                         cycle_no, got[29], got[28:24], got[23:0], want[29], want[28:24], want[23:0]);
            end
            checks++;
            if ($countones(got[7:0]) > 1) begin
                errors++;
                $display("FAIL bus_source cycle %0d: got sources %b, want at most one", cycle_no, got[7:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit h;
        bus.IR   = 32'h0;
        bus.Stop = 1'b0;
        bus.Step = 1'b0;
        @(posedge Clock);
        #1;
        do_reset(3);

        // Directed: add, ld, mul
        run_instr(32'h18918000, -1, h);
        run_instr(32'h00800055, -1, h);
        run_instr(32'h78900000, -1, h);

        // Stop pulse during T4 of add: T5 still completes, then HALT
        run_instr(32'h18918000, 4, h);
        halt_cycles(5);
        do_reset(2);

        // Reset pulled low in T6 of st: Write must never appear
        bus.IR = 32'h10800010;
        build_seq(5'd2);
        for (int k = 0; k < 6; k++) cyc(seq_q[k]);
        #2 Reset = 1'b0;
        cyc(IDLE);
        do_reset(1);
        run_instr(32'h10800010, -1, h);

        // Stop raised in the final step of ld
        run_instr(32'h00800055, 7, h);
        halt_cycles(3);
        do_reset(1);

        // halt opcode
        run_instr(32'hD8000000, -1, h);
        halt_cycles(4);
        do_reset(1);

        // Randomised instruction stream with occasional Stop requests
        repeat (70) begin
            run_instr($urandom, ($urandom_range(0, 11) == 0) ? -2 : -1, h);
            if (h) begin
                halt_cycles(3);
                do_reset(1);
            end
        end

        @(negedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
